// File: rtl/mem_rr_arbiter_if.sv
// Requester/memory bus for mem_rr_arbiter. The slave modport is the arbiter.
// The master modport is the side that drives requests and returns memory read data.
interface mem_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int AW      = 10,
  parameter int DW      = 16
);
  logic                  en;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ-1:0]    req_lock;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [AW-1:0]         mem_raddr;
  logic [DW-1:0]         mem_din;
  logic [DW-1:0]         mem_dout;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [DW-1:0]         rsp_data;

  modport master (
    output en, req, req_we, req_lock, req_addr, req_wdata, mem_dout,
    input  gnt, mem_we, mem_waddr, mem_raddr, mem_din, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  en, req, req_we, req_lock, req_addr, req_wdata, mem_dout,
    output gnt, mem_we, mem_waddr, mem_raddr, mem_din, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between NUM_REQ requesters.
// One operation is granted per cycle. A read's data returns one cycle after its grant,
// tagged with the requester ID. A requester holding req_lock keeps ownership for
// back-to-back beats.
module mem_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int AW      = 10,
  parameter int DW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_rr_arbiter_if.slave    bus
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] owner;
  logic            owner_vld;
  logic            win_vld;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;

  // Winner select: a locked owner keeps the bus; otherwise search starts at ptr+1 and wraps.
  // The loop runs from the farthest candidate to the nearest, so the nearest requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    if (bus.en && !rst) begin
      if (owner_vld && bus.req[owner] && bus.req_lock[owner]) begin
        win_vld = 1'b1;
        win_id  = owner;
      end else begin
        for (int k = NUM_REQ; k >= 1; k--) begin
          cand = ID_W'((int'(ptr) + k) % NUM_REQ);
          if (bus.req[cand]) begin
            win_vld = 1'b1;
            win_id  = cand;
          end
        end
      end
    end
  end

  assign win_we    = bus.req_we[win_id];
  assign win_addr  = bus.req_addr[int'(win_id)*AW +: AW];
  assign win_wdata = bus.req_wdata[int'(win_id)*DW +: DW];

  // Grant and memory port decode; unused ports are held at zero.
  always_comb begin
    bus.gnt       = '0;
    bus.mem_we    = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_raddr = '0;
    bus.mem_din   = '0;
    if (win_vld) begin
      bus.gnt[win_id] = 1'b1;
      if (win_we) begin
        bus.mem_we    = 1'b1;
        bus.mem_waddr = win_addr;
        bus.mem_din   = win_wdata;
      end else begin
        bus.mem_raddr = win_addr;
      end
    end
  end

  // The registered memory output lines up with rsp_valid, so data passes straight through.
  assign bus.rsp_data = bus.mem_dout;

  // Pointer, lock ownership and read-response tagging, updated on every grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= ID_W'(NUM_REQ - 1);
      owner         <= '0;
      owner_vld     <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
    end else if (win_vld) begin
      ptr           <= win_id;
      owner         <= win_id;
      owner_vld     <= bus.req_lock[win_id];
      bus.rsp_valid <= !win_we;
      bus.rsp_id    <= win_id;
    end else begin
      owner_vld     <= 1'b0;
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter. The driver issues directed cycles and queues hand-computed port
// and response expectations. The monitor compares them on the falling edge.
module tb_mem_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   started = 1'b0;

  mem_rr_arbiter_if #(.NUM_REQ(4), .ID_W(2), .AW(10), .DW(16)) bus ();

  mem_rr_arbiter #(.NUM_REQ(4), .ID_W(2), .AW(10), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: registered read, write-before-next-read
  logic [15:0] mem [1024];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_raddr];
  end

  typedef struct {
    int          cyc;
    logic [3:0]  gnt;
    logic        we;
    logic [9:0]  wa;
    logic [9:0]  ra;
    logic [15:0] din;
  } port_t;

  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [15:0] data;
  } rsp_t;

  port_t gq[$];
  rsp_t  rq[$];

  // monitor
  always @(negedge clk) begin
    if (started) begin
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        port_t e;
        e = gq.pop_front();
        checks++;
        if ({bus.gnt, bus.mem_we, bus.mem_waddr, bus.mem_raddr, bus.mem_din} !==
            {e.gnt, e.we, e.wa, e.ra, e.din}) begin
          fails++;
          $display("FAIL port cyc=%0d got gnt=%b we=%b wa=%h ra=%h din=%h exp gnt=%b we=%b wa=%h ra=%h din=%h",
                   cyc, bus.gnt, bus.mem_we, bus.mem_waddr, bus.mem_raddr, bus.mem_din,
                   e.gnt, e.we, e.wa, e.ra, e.din);
        end
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        rsp_t r;
        r = rq.pop_front();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, r.id, r.data}) begin
          fails++;
          $display("FAIL rsp cyc=%0d got valid=%b id=%0d data=%h exp valid=1 id=%0d data=%h",
                   cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, r.id, r.data);
        end
      end else begin
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
          fails++;
          $display("FAIL no_rsp cyc=%0d got valid=%b id=%0d exp valid=0", cyc, bus.rsp_valid, bus.rsp_id);
        end
      end
    end
  end

  task automatic exp_none();
    gq.push_back('{cyc, 4'b0000, 1'b0, 10'h000, 10'h000, 16'h0000});
  endtask

  task automatic exp_read(input logic [3:0] g, input logic [9:0] a);
    gq.push_back('{cyc, g, 1'b0, 10'h000, a, 16'h0000});
  endtask

  task automatic exp_write(input logic [3:0] g, input logic [9:0] a, input logic [15:0] d);
    gq.push_back('{cyc, g, 1'b1, a, 10'h000, d});
  endtask

  task automatic exp_rsp(input logic [1:0] id, input logic [15:0] d);
    rq.push_back('{cyc + 1, id, d});
  endtask

  task automatic drive(input logic e, input logic [3:0] r, input logic [3:0] w, input logic [3:0] l);
    bus.en       = e;
    bus.req      = r;
    bus.req_we   = w;
    bus.req_lock = l;
  endtask

  task automatic set_ad(input int i, input logic [9:0] a, input logic [15:0] d);
    bus.req_addr[i*10 +: 10]  = a;
    bus.req_wdata[i*16 +: 16] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic base_addrs();
    for (int i = 0; i < 4; i++) set_ad(i, 10'h010 + 10'(i), 16'hB000 + 16'(i));
  endtask

  logic [15:0] pre [4];

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d exp finished run", cyc);
    $fatal(1, "timeout");
  end

  // driver
  initial begin
    pre[0] = 16'h1111; pre[1] = 16'h2222; pre[2] = 16'h3333; pre[3] = 16'h4444;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem[16 + i] = pre[i];
    bus.mem_dout = 16'h0000;
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
    base_addrs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;

    // reset mid-traffic
    drive(1'b1, 4'b1111, 4'b0000, 4'b0000);
    exp_read(4'b0001, 10'h010); exp_rsp(2'd0, 16'h1111); tick();
    for (int i = 0; i < 4; i++) set_ad(i, 10'h020 + 10'(i), 16'hB000 + 16'(i));
    drive(1'b1, 4'b1111, 4'b1111, 4'b0000);
    exp_write(4'b0010, 10'h021, 16'hB001); tick();
    base_addrs();
    drive(1'b1, 4'b1111, 4'b0000, 4'b0000);
    exp_none();
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_read(4'b0001, 10'h010); exp_rsp(2'd0, 16'h1111); tick();

    // round-robin, all reading
    for (int k = 0; k < 8; k++) begin
      int id;
      id = (k + 1) % 4;
      exp_read(4'b0001 << id, 10'h010 + 10'(id));
      exp_rsp(2'(id), pre[id]);
      tick();
    end

    // write then read of the same address
    set_ad(0, 10'h3FF, 16'hA5C3);
    drive(1'b1, 4'b0001, 4'b0001, 4'b0000);
    exp_write(4'b0001, 10'h3FF, 16'hA5C3); tick();
    set_ad(2, 10'h3FF, 16'h0000);
    drive(1'b1, 4'b0100, 4'b0000, 4'b0000);
    exp_read(4'b0100, 10'h3FF); exp_rsp(2'd2, 16'hA5C3); tick();
    base_addrs();

    // lock held by requester 1
    drive(1'b1, 4'b0001, 4'b0000, 4'b0000);
    exp_read(4'b0001, 10'h010); exp_rsp(2'd0, 16'h1111); tick();
    drive(1'b1, 4'b1111, 4'b0000, 4'b0010);
    repeat (3) begin
      exp_read(4'b0010, 10'h011); exp_rsp(2'd1, 16'h2222); tick();
    end
    drive(1'b1, 4'b1111, 4'b0000, 4'b0000);
    exp_read(4'b0100, 10'h012); exp_rsp(2'd2, 16'h3333); tick();

    // idle and enable low
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
    exp_none(); tick();
    drive(1'b0, 4'b1111, 4'b0000, 4'b0000);
    exp_none(); tick();
    drive(1'b1, 4'b1111, 4'b0000, 4'b0000);
    exp_read(4'b1000, 10'h013); exp_rsp(2'd3, 16'h4444); tick();

    // enable drops during a lock: the lock is lost
    drive(1'b1, 4'b0010, 4'b0000, 4'b0010);
    exp_read(4'b0010, 10'h011); exp_rsp(2'd1, 16'h2222); tick();
    drive(1'b0, 4'b1111, 4'b0000, 4'b0010);
    exp_none(); tick();
    drive(1'b1, 4'b1111, 4'b0000, 4'b0010);
    exp_read(4'b0100, 10'h012); exp_rsp(2'd2, 16'h3333); tick();

    // sparse requesters 3 and 0 writing, then read back
    drive(1'b1, 4'b0001, 4'b0000, 4'b0000);
    exp_read(4'b0001, 10'h010); exp_rsp(2'd0, 16'h1111); tick();
    set_ad(3, 10'h100, 16'h1234);
    set_ad(0, 10'h101, 16'h5678);
    drive(1'b1, 4'b1001, 4'b1001, 4'b0000);
    repeat (2) begin
      exp_write(4'b1000, 10'h100, 16'h1234); tick();
      exp_write(4'b0001, 10'h101, 16'h5678); tick();
    end
    set_ad(1, 10'h100, 16'h0000);
    drive(1'b1, 4'b0010, 4'b0000, 4'b0000);
    exp_read(4'b0010, 10'h100); exp_rsp(2'd1, 16'h1234); tick();
    set_ad(2, 10'h101, 16'h0000);
    drive(1'b1, 4'b0100, 4'b0000, 4'b0000);
    exp_read(4'b0100, 10'h101); exp_rsp(2'd2, 16'h5678); tick();
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
    exp_none(); tick();
    tick();

    checks++;
    if (gq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL leftover got port=%0d rsp=%0d pending exp 0", gq.size(), rq.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
